// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider,
// one-cycle sign fixup. Divide-by-zero and signed overflow bypass iteration.
module mul_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned W2 = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;    // |op_a| for multiply
  logic [XLEN-1:0]   mplier_q, mplier_d;  // |op_b|: multiplier, or divisor
  logic [W2-1:0]     acc_q, acc_d;        // product, or {rem, quo}
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Accept-time decode
  logic            sa_in, sb_in, is_div, div0, ovf, accept;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  // Iteration and fixup datapath
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_acc;
  logic [XLEN:0]   div_rem_sh, div_diff;
  logic            div_ge;
  logic [W2-1:0]   div_acc;
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quo, rem, fix_res;

  // Operand decode for a request presented in IDLE
  always_comb begin
    accept = (state_q == StIdle) && start && !flush;
    is_div = funct3[2];
    sa_in  = op_a[XLEN-1] && (funct3 == 3'b001 || funct3 == 3'b010 ||
                              funct3 == 3'b100 || funct3 == 3'b110);
    sb_in  = op_b[XLEN-1] && (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    abs_a  = sa_in ? -op_a : op_a;
    abs_b  = sb_in ? -op_b : op_b;
    div0   = is_div && (op_b == '0);
    ovf    = (funct3 == 3'b100 || funct3 == 3'b110) &&
             (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    if (div0) begin
      fast_res = funct3[1] ? op_a : '1;
    end else begin
      fast_res = funct3[1] ? '0 : op_a;
    end
  end

  // One multiply or divide step, plus the final sign correction
  always_comb begin
    mul_sum    = {1'b0, acc_q[W2-1:XLEN]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mul_acc    = {mul_sum, acc_q[XLEN-1:1]};
    div_rem_sh = acc_q[W2-1:XLEN-1];
    div_diff   = div_rem_sh - {1'b0, mplier_q};
    // Remainder stays below the divisor, so the XLEN+1-bit difference sign is the compare
    div_ge     = ~div_diff[XLEN];
    div_acc    = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                        : {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    prod       = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo        = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem        = sa_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
    case (funct3_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[W2-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (div0 || ovf) ? StDone : StCalc;
      StCalc:  if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFixup;
      StFixup: state_d = StDone;
      StDone:  state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Datapath next-state: latch at accept, iterate in CALC, commit result in FIXUP
  always_comb begin
    funct3_d = funct3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = funct3;
          sa_d     = sa_in;
          sb_d     = sb_in;
          mcand_d  = abs_a;
          mplier_d = abs_b;
          acc_d    = is_div ? {{XLEN{1'b0}}, abs_a} : '0;
          cnt_d    = '0;
          if (div0 || ovf) result_d = fast_res;
        end
      end
      StCalc: begin
        acc_d    = funct3_q[2] ? div_acc : mul_acc;
        mplier_d = funct3_q[2] ? mplier_q : (mplier_q >> 1);
        cnt_d    = cnt_q + CNT_W'(1);
      end
      StFixup: begin
        if (!flush) result_d = fix_res;
      end
      StDone: ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    result = result_q;
  end

endmodule
